// File: rtl/alu_word_sequencer_if.sv
// Request and ALU-side signal bundle for alu_word_sequencer.
//   master : used by the sequencer. It takes the request (Start/Op/OpA/OpB)
//            and the ALU result/flags, and it drives the ALU controls and the
//            completion status.
//   slave  : used by the environment. It drives the request and models the ALU.
interface alu_word_sequencer_if;
  logic        Start;
  logic [2:0]  Op;
  logic [31:0] OpA;
  logic [31:0] OpB;
  logic [15:0] AluA;
  logic [15:0] AluB;
  logic [4:0]  AluFunSel;
  logic        AluWF;
  logic [15:0] AluOut;
  logic [3:0]  AluFlags;
  logic [31:0] Result;
  logic [3:0]  ResultFlags;
  logic        Busy;
  logic        Done;

  modport master (
    input  Start, Op, OpA, OpB, AluOut, AluFlags,
    output AluA, AluB, AluFunSel, AluWF, Result, ResultFlags, Busy, Done
  );

  modport slave (
    output Start, Op, OpA, OpB, AluOut, AluFlags,
    input  AluA, AluB, AluFunSel, AluWF, Result, ResultFlags, Busy, Done
  );
endinterface

// File: rtl/alu_word_sequencer.sv
// alu_word_sequencer: runs one 32-bit operation as two 16-bit ALU word cycles.
// The result and the merged {Z,C,N,O} flags are returned in registers.
// Ports:
//   Clock       in   system clock, rising edge
//   Reset       in   asynchronous, active-high reset
//   bus         master modport of alu_word_sequencer_if. It carries:
//               Start/Op/OpA/OpB (request), AluA/AluB/AluFunSel/AluWF (ALU drive),
//               AluOut/AluFlags (ALU response), Result/ResultFlags/Busy/Done (status)
// Build option: define ALU_SEQ_CMP_EN to make Op=111 a CMP32 (flags only).
// Without it, Op=111 is a no-op that completes without touching the ALU.
//
// state | meaning
// IDLE  | waiting for Start, ALU inputs parked
// LO    | first word cycle, AluWF=1 (this is the high word for SHR32)
// WAIT1 | FLAG_WAIT cycles letting the first-word flags settle
// HI    | second word cycle, AluWF=1
// WAIT2 | FLAG_WAIT cycles letting the second-word flags settle
// FIN   | result and flags are assembled
module alu_word_sequencer #(
  parameter logic [4:0]  IDLE_FUNSEL = 5'b10000,
  parameter int unsigned FLAG_WAIT   = 0
) (
  input logic                  Clock,
  input logic                  Reset,
  alu_word_sequencer_if.master bus
);
  typedef enum logic [2:0] {IDLE, LO, WAIT1, HI, WAIT2, FIN} state_t;

  localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd2, OP_OR = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4, OP_SHL = 3'd5, OP_SHR = 3'd6, OP_X = 3'd7;
  localparam logic [1:0] WAIT_LOAD = 2'(FLAG_WAIT - 1);

`ifdef ALU_SEQ_CMP_EN
  localparam logic CMP_EN = 1'b1;
`else
  localparam logic CMP_EN = 1'b0;
`endif

  state_t      state, state_d;
  logic [2:0]  op_q;
  logic [31:0] opa_q, opb_q;
  logic [15:0] first_q, second_q;
  logic [1:0]  wait_cnt;
  logic [31:0] result_q;
  logic [3:0]  flags_q;
  logic        done_q;

  logic        second, upper;
  logic [15:0] word_a, word_b;
  logic [4:0]  word_fs;
  logic [15:0] alu_a, alu_b;
  logic [4:0]  alu_fs;
  logic        alu_wf;
  logic [31:0] full;
  logic        c_bit, o_bit;
  logic        is_noop, is_cmp;

  // Z and N are derived from the 32-bit result, so the ALU's own Z/N are not read.
  logic unused_flags;
  assign unused_flags = ^{bus.AluFlags[3], bus.AluFlags[1]};

  assign is_noop = (op_q == OP_X) && !CMP_EN;
  assign is_cmp  = (op_q == OP_X) && CMP_EN;

  // Word program for the current word cycle. SHR32 works from the top down,
  // so that the LSR carry can feed the ROR of the low word.
  always_comb begin
    second  = (state == HI) || (state == WAIT2);
    upper   = second ^ (op_q == OP_SHR);
    word_a  = upper ? opa_q[31:16] : opa_q[15:0];
    word_b  = upper ? opb_q[31:16] : opb_q[15:0];
    word_fs = IDLE_FUNSEL;
    case (op_q)
      OP_ADD: word_fs = second ? 5'b10101 : 5'b10100;
      OP_SUB, OP_X: begin
        // The high word is A + ~B + C. This makes C the no-borrow flag of the low SUB.
        word_fs = second ? 5'b10101 : 5'b10110;
        if (second) word_b = ~opb_q[31:16];
      end
      OP_AND: word_fs = 5'b10111;
      OP_OR:  word_fs = 5'b11000;
      OP_XOR: word_fs = 5'b11001;
      OP_SHL: word_fs = second ? 5'b11110 : 5'b11011;
      OP_SHR: word_fs = second ? 5'b11111 : 5'b11100;
      default: word_fs = IDLE_FUNSEL;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d = state;
    alu_a   = '0;
    alu_b   = '0;
    alu_fs  = IDLE_FUNSEL;
    alu_wf  = 1'b0;
    case (state)
      IDLE:  if (bus.Start) state_d = ((bus.Op == OP_X) && !CMP_EN) ? FIN : LO;
      LO:    state_d = (FLAG_WAIT == 0) ? HI : WAIT1;
      WAIT1: if (wait_cnt == 2'd0) state_d = HI;
      HI:    state_d = (FLAG_WAIT == 0) ? FIN : WAIT2;
      WAIT2: if (wait_cnt == 2'd0) state_d = FIN;
      FIN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (state inside {LO, WAIT1, HI, WAIT2}) begin
      alu_a  = word_a;
      alu_b  = word_b;
      alu_fs = word_fs;
      alu_wf = (state == LO) || (state == HI);
    end
  end

  always_comb begin
    full  = (op_q == OP_SHR) ? {first_q, second_q} : {second_q, first_q};
    c_bit = 1'b0;
    o_bit = 1'b0;
    if (op_q inside {OP_ADD, OP_SUB, OP_SHL, OP_SHR, OP_X}) c_bit = bus.AluFlags[2];
    if (op_q inside {OP_ADD, OP_SUB, OP_X})                 o_bit = bus.AluFlags[0];
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      op_q     <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      first_q  <= '0;
      second_q <= '0;
      wait_cnt <= '0;
      result_q <= '0;
      flags_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= (state == FIN);
      if (state == IDLE && bus.Start) begin
        op_q  <= bus.Op;
        opa_q <= bus.OpA;
        opb_q <= bus.OpB;
      end
      if (state == LO) first_q  <= bus.AluOut;
      if (state == HI) second_q <= bus.AluOut;
      if (state == LO || state == HI)
        wait_cnt <= WAIT_LOAD;
      else if (state == WAIT1 || state == WAIT2)
        wait_cnt <= wait_cnt - 2'd1;
      if (state == FIN && !is_noop) begin
        if (!is_cmp) result_q <= full;
        flags_q <= {full == 32'd0, c_bit, full[31], o_bit};
      end
    end
  end

  assign bus.AluA        = alu_a;
  assign bus.AluB        = alu_b;
  assign bus.AluFunSel   = alu_fs;
  assign bus.AluWF       = alu_wf;
  assign bus.Result      = result_q;
  assign bus.ResultFlags = flags_q;
  assign bus.Busy        = (state != IDLE);
  assign bus.Done        = done_q;
endmodule

// File: tb/tb_alu_word_sequencer.sv
module tb_alu_word_sequencer;
  localparam int         FW      = 0;
  localparam logic [4:0] IDLE_FS = 5'b10000;
`ifdef ALU_SEQ_CMP_EN
  localparam bit CMP_EN = 1'b1;
`else
  localparam bit CMP_EN = 1'b0;
`endif

  logic Clock = 1'b0;
  logic Reset;
  int   tests_run = 0;
  int   failed = 0;
  logic [31:0] model_res;
  logic [3:0]  model_flg;

  always #5 Clock = ~Clock;

  alu_word_sequencer_if bus();

  alu_word_sequencer #(.IDLE_FUNSEL(IDLE_FS), .FLAG_WAIT(FW)) dut (
    .Clock(Clock),
    .Reset(Reset),
    .bus  (bus)
  );

  // 16-bit ALU model: the result is combinational and {Z,C,N,O} is written when WF=1.
  logic [3:0]  alu_flags_q;
  logic [16:0] alu_s;
  logic [15:0] alu_r;
  logic        alu_c, alu_o;
  always_comb begin
    alu_s = '0; alu_r = '0; alu_c = 1'b0; alu_o = 1'b0;
    case (bus.AluFunSel)
      5'b10100, 5'b10101: begin
        alu_s = {1'b0, bus.AluA} + {1'b0, bus.AluB}
              + {16'd0, (bus.AluFunSel == 5'b10101) & alu_flags_q[2]};
        alu_r = alu_s[15:0]; alu_c = alu_s[16];
        alu_o = (bus.AluA[15] == bus.AluB[15]) && (alu_r[15] != bus.AluA[15]);
      end
      5'b10110: begin
        alu_s = {1'b0, bus.AluA} + {1'b0, ~bus.AluB} + 17'd1;
        alu_r = alu_s[15:0]; alu_c = alu_s[16];
        alu_o = (bus.AluA[15] != bus.AluB[15]) && (alu_r[15] != bus.AluA[15]);
      end
      5'b10111: alu_r = bus.AluA & bus.AluB;
      5'b11000: alu_r = bus.AluA | bus.AluB;
      5'b11001: alu_r = bus.AluA ^ bus.AluB;
      5'b11011: begin alu_r = {bus.AluA[14:0], 1'b0};           alu_c = bus.AluA[15]; end
      5'b11110: begin alu_r = {bus.AluA[14:0], alu_flags_q[2]}; alu_c = bus.AluA[15]; end
      5'b11100: begin alu_r = {1'b0, bus.AluA[15:1]};           alu_c = bus.AluA[0];  end
      5'b11111: begin alu_r = {alu_flags_q[2], bus.AluA[15:1]}; alu_c = bus.AluA[0];  end
      default: alu_r = '0;
    endcase
  end
  always @(posedge Clock or posedge Reset)
    if (Reset) alu_flags_q <= '0;
    else if (bus.AluWF) alu_flags_q <= {alu_r == 16'd0, alu_c, alu_r[15], alu_o};
  assign bus.AluOut   = alu_r;
  assign bus.AluFlags = alu_flags_q;

  // 32-bit reference model: {Z,C,N,O}, where C on SUB means no borrow.
  function automatic void ref_op(input logic [2:0] op, input logic [31:0] a, b,
                                 input logic [31:0] res_in, input logic [3:0] flg_in,
                                 output logic [31:0] res_o, output logic [3:0] flg_o);
    logic [32:0] w;
    logic [31:0] r;
    logic c, o, upd_res, upd_flg;
    r = '0; c = 1'b0; o = 1'b0; upd_res = 1'b1; upd_flg = 1'b1;
    case (op)
      3'd0: begin
        w = {1'b0, a} + {1'b0, b}; r = w[31:0]; c = w[32];
        o = (a[31] == b[31]) && (r[31] != a[31]);
      end
      3'd1, 3'd7: begin
        r = a - b; c = (a >= b);
        o = (a[31] != b[31]) && (r[31] != a[31]);
        if (op == 3'd7) begin upd_res = 1'b0; upd_flg = CMP_EN; end
      end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: begin r = a << 1; c = a[31]; end
      default: begin r = a >> 1; c = a[0]; end
    endcase
    res_o = upd_res ? r : res_in;
    flg_o = upd_flg ? {r == 32'd0, c, r[31], o} : flg_in;
  endfunction

  function automatic int exp_lat(input logic [2:0] op);
    return (op == 3'd7 && !CMP_EN) ? 2 : 4 + 2 * FW;
  endfunction

  function automatic logic [31:0] pick32();
    logic [31:0] v;
    v = $urandom;
    case ($urandom_range(0, 5))
      0: v = 32'h0000_0000;
      1: v = 32'hFFFF_FFFF;
      2: v = 32'h7FFF_FFFF;
      3: v = 32'h8000_0000;
      4: v = {16'h0000, v[15:0]};
      default: ;
    endcase
    return v;
  endfunction

  // Issues one request and then returns in the Done cycle, #1 after the clock edge.
  // lat counts cycles: the cycle that begins at the accepting edge is cycle 1.
  // lat is -1 if Done does not arrive within the budget.
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, b,
                       output int lat, output int wf_cnt,
                       output logic [4:0] fs0, output logic [4:0] fs1, output logic [15:0] a0);
    @(negedge Clock);
    bus.Start = 1'b1; bus.Op = op; bus.OpA = a; bus.OpB = b;
    @(posedge Clock); #1;
    bus.Start = 1'b0; bus.OpA = $urandom; bus.OpB = $urandom; bus.Op = 3'($urandom);
    lat = -1; wf_cnt = 0; fs0 = '0; fs1 = '0; a0 = '0;
    for (int n = 1; n <= 40; n++) begin
      if (bus.AluWF) begin
        if (wf_cnt == 0) begin fs0 = bus.AluFunSel; a0 = bus.AluA; end
        else if (wf_cnt == 1) fs1 = bus.AluFunSel;
        wf_cnt++;
      end
      if (bus.Done) begin lat = n; break; end
      @(posedge Clock); #1;
    end
  endtask

  task automatic test_reset();
    bus.Start = 1'b0; bus.Op = '0; bus.OpA = '0; bus.OpB = '0;
    Reset = 1'b1;
    #1;
    tests_run++;
    if ({bus.Result, bus.ResultFlags, bus.Busy, bus.Done, bus.AluWF} !== 39'd0) begin
      failed++;
      $display("FAIL reset_outputs: got res=%h flg=%b busy=%b done=%b wf=%b expected all 0",
               bus.Result, bus.ResultFlags, bus.Busy, bus.Done, bus.AluWF);
    end
    tests_run++;
    if ({bus.AluFunSel, bus.AluA, bus.AluB} !== {IDLE_FS, 32'd0}) begin
      failed++;
      $display("FAIL reset_alu_idle: got fs=%b a=%h b=%h expected fs=%b a=0 b=0",
               bus.AluFunSel, bus.AluA, bus.AluB, IDLE_FS);
    end
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    Reset = 1'b0;
    model_res = '0; model_flg = '0;
  endtask

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] a, b, r;
    logic [3:0]  f;
  } vec_t;

  task automatic test_directed();
    vec_t vecs [8] = '{
      '{3'd0, 32'h0000FFFF, 32'h00000001, 32'h00010000, 4'b0000},
      '{3'd1, 32'h00010000, 32'h00000001, 32'h0000FFFF, 4'b0100},
      '{3'd1, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 4'b0010},
      '{3'd0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 4'b0011},
      '{3'd5, 32'h80008000, 32'h00000000, 32'h00010000, 4'b0100},
      '{3'd6, 32'h00010001, 32'h00000000, 32'h00008000, 4'b0100},
      '{3'd2, 32'hF0F0F0F0, 32'h0F0F0F0F, 32'h00000000, 4'b1000},
      '{3'd0, 32'h00000001, 32'h00000000, 32'h00000001, 4'b0000}};
    int lat, wf;
    logic [4:0] fs0, fs1;
    logic [15:0] a0;
    for (int i = 0; i < 8; i++) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, wf, fs0, fs1, a0);
      tests_run++;
      if (bus.Result !== vecs[i].r || bus.ResultFlags !== vecs[i].f) begin
        failed++;
        $display("FAIL directed_%0d: got res=%h flg=%b expected res=%h flg=%b",
                 i, bus.Result, bus.ResultFlags, vecs[i].r, vecs[i].f);
      end
      tests_run++;
      if (lat !== exp_lat(vecs[i].op) || wf !== 2 || bus.Busy !== 1'b0) begin
        failed++;
        $display("FAIL directed_timing_%0d: got lat=%0d wf=%0d busy=%b expected lat=%0d wf=2 busy=0",
                 i, lat, wf, bus.Busy, exp_lat(vecs[i].op));
      end
      if (i == 0) begin
        tests_run++;
        if (fs0 !== 5'b10100 || fs1 !== 5'b10101) begin
          failed++;
          $display("FAIL add_funsel: got %b,%b expected 10100,10101", fs0, fs1);
        end
      end
      if (i == 5) begin
        tests_run++;
        if (fs0 !== 5'b11100 || fs1 !== 5'b11111 || a0 !== 16'h0001) begin
          failed++;
          $display("FAIL shr_order: got fs=%b,%b first A=%h expected 11100,11111 A=0001", fs0, fs1, a0);
        end
      end
      model_res = vecs[i].r; model_flg = vecs[i].f;
    end
  endtask

  task automatic test_busy_ignore();
    logic [31:0] er;
    logic [3:0]  ef;
    int dones;
    ref_op(3'd2, 32'hF0F0F0F0, 32'h0F0F0F0F, model_res, model_flg, er, ef);
    @(negedge Clock);
    bus.Start = 1'b1; bus.Op = 3'd2; bus.OpA = 32'hF0F0F0F0; bus.OpB = 32'h0F0F0F0F;
    @(posedge Clock); #1;
    bus.Start = 1'b0;
    dones = 0;
    for (int n = 1; n <= 12; n++) begin
      if (n == 1) begin bus.Start = 1'b1; bus.Op = 3'd0; bus.OpA = 32'h12345678; bus.OpB = 32'h1; end
      if (n == 3) bus.Start = 1'b0;
      if (bus.Done) dones++;
      @(posedge Clock); #1;
    end
    tests_run++;
    if (dones !== 1) begin
      failed++;
      $display("FAIL busy_ignore_done_count: got %0d expected 1", dones);
    end
    tests_run++;
    if (bus.Result !== er || bus.ResultFlags !== ef) begin
      failed++;
      $display("FAIL busy_ignore_result: got res=%h flg=%b expected res=%h flg=%b",
               bus.Result, bus.ResultFlags, er, ef);
    end
    model_res = er; model_flg = ef;
  endtask

  task automatic test_random();
    logic [2:0]  op;
    logic [31:0] a, b, er;
    logic [3:0]  ef;
    int lat, wf;
    logic [4:0] fs0, fs1;
    logic [15:0] a0;
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      a = pick32(); b = pick32();
      ref_op(op, a, b, model_res, model_flg, er, ef);
      do_op(op, a, b, lat, wf, fs0, fs1, a0);
      tests_run++;
      if (bus.Result !== er || bus.ResultFlags !== ef || lat !== exp_lat(op)) begin
        failed++;
        $display("FAIL random_%0d op=%0d a=%h b=%h: got res=%h flg=%b lat=%0d expected res=%h flg=%b lat=%0d",
                 i, op, a, b, bus.Result, bus.ResultFlags, lat, er, ef, exp_lat(op));
      end
      model_res = er; model_flg = ef;
    end
  endtask

  task automatic test_back_to_back();
    int lat, wf;
    logic [4:0] fs0, fs1;
    logic [15:0] a0;
    do_op(3'd3, 32'h00F0_0000, 32'h0000_000F, lat, wf, fs0, fs1, a0);
    tests_run++;
    if (bus.Done !== 1'b1) begin
      failed++;
      $display("FAIL b2b_done_cycle: got done=%b expected 1", bus.Done);
    end
    // do_op raises Start in this Done cycle, so the second request is sampled right after Done.
    do_op(3'd4, 32'hAAAA_5555, 32'hFFFF_0000, lat, wf, fs0, fs1, a0);
    tests_run++;
    if (bus.Result !== 32'h5555_5555 || bus.ResultFlags !== 4'b0000 || lat !== 4 + 2 * FW) begin
      failed++;
      $display("FAIL b2b_second: got res=%h flg=%b lat=%0d expected res=55555555 flg=0000 lat=%0d",
               bus.Result, bus.ResultFlags, lat, 4 + 2 * FW);
    end
    model_res = 32'h5555_5555; model_flg = 4'b0000;
  endtask

  task automatic test_op7();
    logic [31:0] er;
    logic [3:0]  ef;
    int lat, wf;
    logic [4:0] fs0, fs1;
    logic [15:0] a0;
    do_op(3'd0, 32'h10, 32'h20, lat, wf, fs0, fs1, a0);
    model_res = 32'h30; model_flg = 4'b0000;
    ref_op(3'd7, 32'd5, 32'd9, model_res, model_flg, er, ef);
    do_op(3'd7, 32'd5, 32'd9, lat, wf, fs0, fs1, a0);
    tests_run++;
    if (bus.Result !== er || bus.ResultFlags !== ef) begin
      failed++;
      $display("FAIL op7_result: got res=%h flg=%b expected res=%h flg=%b",
               bus.Result, bus.ResultFlags, er, ef);
    end
    tests_run++;
    if (lat !== exp_lat(3'd7) || wf !== (CMP_EN ? 2 : 0)) begin
      failed++;
      $display("FAIL op7_timing: got lat=%0d wf=%0d expected lat=%0d wf=%0d",
               lat, wf, exp_lat(3'd7), CMP_EN ? 2 : 0);
    end
    model_res = er; model_flg = ef;
  endtask

  task automatic test_reset_mid();
    int lat, wf, dones;
    logic [4:0] fs0, fs1;
    logic [15:0] a0;
    do_op(3'd0, 32'd1, 32'd2, lat, wf, fs0, fs1, a0);
    tests_run++;
    if (bus.Result !== 32'd3) begin
      failed++;
      $display("FAIL pre_reset_result: got %h expected 00000003", bus.Result);
    end
    @(negedge Clock);
    bus.Start = 1'b1; bus.Op = 3'd0; bus.OpA = 32'h1111_1111; bus.OpB = 32'h2222_2222;
    @(posedge Clock); #1;
    bus.Start = 1'b0;
    repeat (1 + FW) begin @(posedge Clock); #1; end
    tests_run++;
    if (bus.AluWF !== 1'b1 || bus.AluFunSel !== 5'b10101) begin
      failed++;
      $display("FAIL reach_hi: got wf=%b fs=%b expected wf=1 fs=10101", bus.AluWF, bus.AluFunSel);
    end
    Reset = 1'b1;
    #1;
    tests_run++;
    if ({bus.Busy, bus.AluWF, bus.Done, bus.Result, bus.ResultFlags} !== 39'd0 ||
        bus.AluFunSel !== IDLE_FS) begin
      failed++;
      $display("FAIL reset_mid: got busy=%b wf=%b done=%b res=%h flg=%b fs=%b expected zeros fs=%b",
               bus.Busy, bus.AluWF, bus.Done, bus.Result, bus.ResultFlags, bus.AluFunSel, IDLE_FS);
    end
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    Reset = 1'b0;
    dones = 0;
    for (int n = 0; n < 8; n++) begin
      @(posedge Clock); #1;
      if (bus.Done) dones++;
    end
    tests_run++;
    if (dones !== 0) begin
      failed++;
      $display("FAIL reset_mid_no_done: got %0d Done pulses expected 0", dones);
    end
    model_res = '0; model_flg = '0;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_busy_ignore();
    test_back_to_back();
    test_random();
    test_op7();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/alu_word_sequencer.md
Name: alu_word_sequencer

Overview:
- Control-side master for the 16-bit ALU: accepts one 32-bit operation request and drives the ALU's FunSel/WF/A/B inputs for two consecutive word cycles, low word first.
- Consumes the ALU's combinational result and its registered flags {Z,C,N,O}.
- Returns a 32-bit result with merged 32-bit flags.
- Sits between the datapath control logic and the ALU; the ALU itself is unchanged.

Parameters:
- IDLE_FUNSEL, 5'b10000, FunSel value driven to the ALU whenever the sequencer is not in a word cycle.
- FLAG_WAIT, 0, extra wait cycles (0..3) inserted after each WF write before the ALU flags are consumed.

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Start  in  1  request strobe; sampled only in IDLE.
- Op  in  3  000 ADD32, 001 SUB32, 010 AND32, 011 OR32, 100 XOR32, 101 SHL32, 110 SHR32, 111 see Optional Feature.
- OpA, OpB  in  32  operands; captured on accepted Start.
- AluA, AluB  out  16  ALU operand words.
- AluFunSel  out  5  ALU function select.
- AluWF  out  1  ALU flag write enable.
- AluOut  in  16  ALU result, combinational.
- AluFlags  in  4  ALU FlagsOut; [3]=Z [2]=C [1]=N [0]=O.
- Result  out  32  registered 32-bit result.
- ResultFlags  out  4  registered {Z,C,N,O} of the 32-bit operation.
- Busy  out  1  high while an operation is in progress.
- Done  out  1  one-cycle completion pulse.

Behaviour:
- Interface: one clock (Clock); reset (Reset) is asynchronous and active-high.
- Reset values: all outputs 0, except AluFunSel=IDLE_FUNSEL. Reset takes effect immediately, including mid-operation:
  - state returns to IDLE and AluWF drops at once;
  - no Done pulse is produced;
  - Result and ResultFlags are cleared.
- States: IDLE, LO, WAIT1, HI, WAIT2, FIN.
- IDLE:
  - ALU inputs are idle (AluA/AluB=0, AluFunSel=IDLE_FUNSEL, AluWF=0).
  - Start=1 latches Op/OpA/OpB and moves to LO.
- LO/HI: drive one word with AluWF=1. At the edge leaving the state, AluOut is captured into the low or high result word.
- WAIT1/WAIT2: each lasts FLAG_WAIT cycles with AluWF=0 and FunSel/operands held; skipped when FLAG_WAIT=0.
- Transitions: LO -> WAIT1 -> HI -> WAIT2 -> FIN -> IDLE.
- Word programs, listed as first word / second word:
  - ADD32: lo 10100 / hi 10101, carry chains through ALU flag C.
  - SUB32: lo 10110 with B=OpB[15:0] / hi 10101 with AluB=~OpB[31:16]. C=1 means no borrow.
  - AND32/OR32/XOR32: 10111 / 11000 / 11001 on both words.
  - SHL32: lo 11011 (LSL) / hi 11110 (ROL, shifts in C).
  - SHR32: hi 11100 (LSR) is issued first, then lo 11111 (ROR). First/second word order is swapped for this op only.
- FIN:
  - Result <= {hi,lo}.
  - ResultFlags: Z=(full 32-bit result==0), computed locally rather than from ALU Z. C=AluFlags[2] for ADD/SUB/shift, 0 for logic. N=Result[31]. O=AluFlags[0] for ADD/SUB, 0 otherwise.
- Done: registered pulse in the cycle after FIN, coincident with Busy=0.
- Busy: high in LO..FIN.
- Latency: Start edge to Done = 4 + 2*FLAG_WAIT cycles.
- Start while Busy is ignored, with no queueing. Start in the Done cycle is accepted.
- OpA/OpB changes after acceptance have no effect.
- Result/ResultFlags hold until the next FIN or reset.

Optional Feature:
- Macro ALU_SEQ_CMP_EN.
- Defined: Op=111 is CMP32. It runs the SUB32 word program and updates ResultFlags as for SUB32. Result is left unchanged, with the same latency as SUB32.
- Undefined: Op=111 is a no-op:
  - the sequencer goes IDLE -> FIN directly;
  - AluWF stays 0 throughout;
  - Result and ResultFlags are unchanged;
  - Done pulses 2 cycles after the Start edge.

Test Plan:
- ADD32 0x0000FFFF+0x00000001 (FLAG_WAIT=0) -> AluFunSel 10100 then 10101; Result=0x00010000, ResultFlags=0000; Done 4 cycles after Start.
- SUB32 0x00010000-0x00000001 -> 0x0000FFFF, C=1, N=0. SUB32 0x00000000-0x00000001 -> 0xFFFFFFFF, C=0, N=1.
- ADD32 0x7FFFFFFF+0x00000001 -> 0x80000000, N=1, O=1, C=0.
- SHL32 0x80008000 -> 0x00010000, C=1. SHR32 0x00010001 -> hi word issued first; Result=0x00008000, C=1.
- AND32 0xF0F0F0F0&0x0F0F0F0F -> 0x00000000, Z=1, C=0. A second Start pulsed during Busy produces no extra Done.
- Reset asserted during HI -> Busy, AluWF, Result and Done go 0 immediately. Op=111 -> CMP flags only with the macro; no ALU write and Done after 2 cycles without it.
